// File: rtl/bitslice_pkg.sv
// Shared encodings for the bit-slice ALU: operand sources, ALU functions,
// destination/shift modes and repeat-sequencer states.
package bitslice_pkg;

    typedef enum logic [2:0] {
        SRC_AQ, SRC_AB, SRC_ZQ, SRC_ZB, SRC_ZA, SRC_DA, SRC_DQ, SRC_DZ
    } src_e;

    typedef enum logic [2:0] {
        FN_ADD, FN_SUBR, FN_SUBS, FN_OR, FN_AND, FN_NOTRS, FN_EXOR, FN_EXNOR
    } fn_e;

    typedef enum logic [2:0] {
        DST_QREG, DST_NOP, DST_RAMA, DST_RAMF, DST_RAMQD, DST_RAMD, DST_RAMQU, DST_RAMU
    } dst_e;

    typedef enum logic [1:0] {
        REP_IDLE, REP_BUSY, REP_DONE
    } rep_state_e;

    // Arithmetic functions are the first three encodings; the rest are bitwise.
    function automatic logic fn_is_arith(fn_e f);
        return (f == FN_ADD) || (f == FN_SUBR) || (f == FN_SUBS);
    endfunction

endpackage

// File: rtl/bitslice_regfile.sv
// NREG x W register file: two combinational read ports, one synchronous
// write port, synchronous whole-array clear that overrides the write.
module bitslice_regfile
#(
    parameter int W    = 4,
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic          cp,
    input  logic          clr,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [W-1:0]  rd_a,
    output logic [W-1:0]  rd_b,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd
);

    logic [NREG-1:0][W-1:0] mem_q, mem_d;

    assign rd_a = mem_q[ra];
    assign rd_b = mem_q[rb];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[wa] = wd;
    end

    always_ff @(posedge cp) begin
        if (clr) mem_q <= '0;
        else     mem_q <= mem_d;
    end

endmodule

// File: rtl/bitslice_alu.sv
// Bit-slice ALU with register file, Q register, shifter and a repeat
// sequencer that re-executes a latched instruction rep_count times.
module bitslice_alu
    import bitslice_pkg::*;
#(
    parameter  int W    = 4,
    parameter  int NREG = 16,
    parameter  int CW   = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          cp,
    input  logic          reset_lo,
    input  logic [8:0]    i,
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic [W-1:0]  d,
    input  logic          cin,
    input  logic          oe,
    output logic [W-1:0]  y,
    output logic          cout,
    output logic          g_lo,
    output logic          p_lo,
    output logic          ovr,
    output logic          z,
    output logic          f_msb,
    input  logic          ram_lsb_in,
    input  logic          ram_msb_in,
    input  logic          q_lsb_in,
    input  logic          q_msb_in,
    output logic          ram_lsb_out,
    output logic          ram_msb_out,
    output logic          q_lsb_out,
    output logic          q_msb_out,
    output logic          ram_lsb_oe,
    output logic          ram_msb_oe,
    output logic          q_lsb_oe,
    output logic          q_msb_oe,
    input  logic          rep_start,
    input  logic [CW-1:0] rep_count,
    output logic          busy,
    output logic          done
);

    rep_state_e    state_q;
    logic [8:0]    ir_q;
    logic [AW-1:0] ra_q, rb_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q;
    logic [W-1:0]  q_q, q_d;

    logic [8:0]    ir;
    logic [AW-1:0] ea, eb;
    src_e          src;
    fn_e           fn;
    dst_e          dst;
    logic          wr_en;
    logic [W-1:0]  rd_a, rd_b;
    logic [W-1:0]  r, s, op_x, op_y, f, y_int, reg_wd, q_next;
    logic [W:0]    sum;
    logic [W-1:0]  low;
    logic          arith, reg_we, reg_wr;
    logic          gacc, pacc;

    // While busy the latched instruction and addresses replace the live ones.
    assign ir    = busy_q ? ir_q : i;
    assign ea    = busy_q ? ra_q : a;
    assign eb    = busy_q ? rb_q : b;
    assign src   = src_e'(ir[2:0]);
    assign fn    = fn_e'(ir[5:3]);
    assign dst   = dst_e'(ir[8:6]);
    // The cycle that accepts a repeat only latches; it must not write.
    assign wr_en = !(state_q == REP_IDLE && rep_start);

    bitslice_regfile #(.W(W), .NREG(NREG), .AW(AW)) u_rf (
        .cp   (cp),
        .clr  (!reset_lo),
        .ra   (ea),
        .rb   (eb),
        .rd_a (rd_a),
        .rd_b (rd_b),
        .we   (reg_we),
        .wa   (eb),
        .wd   (reg_wd)
    );

    always_comb begin
        r = '0;
        s = '0;
        case (src)
            SRC_AQ: begin r = rd_a; s = q_q;  end
            SRC_AB: begin r = rd_a; s = rd_b; end
            SRC_ZQ: s = q_q;
            SRC_ZB: s = rd_b;
            SRC_ZA: s = rd_a;
            SRC_DA: begin r = d; s = rd_a; end
            SRC_DQ: begin r = d; s = q_q;  end
            SRC_DZ: r = d;
            default: ;
        endcase
    end

    always_comb begin
        arith = fn_is_arith(fn);
        op_x  = r;
        op_y  = s;
        if (fn == FN_SUBR) begin op_x = s; op_y = ~r; end
        if (fn == FN_SUBS) begin op_x = r; op_y = ~s; end
        sum = {1'b0, op_x} + {1'b0, op_y} + {{W{1'b0}}, cin};
        // Sum of the low W-1 bits exposes the carry into the MSB for overflow.
        low = {1'b0, op_x[W-2:0]} + {1'b0, op_y[W-2:0]} + {{(W-1){1'b0}}, cin};
        case (fn)
            FN_OR:    f = r | s;
            FN_AND:   f = r & s;
            FN_NOTRS: f = ~r & s;
            FN_EXOR:  f = r ^ s;
            FN_EXNOR: f = ~(r ^ s);
            default:  f = sum[W-1:0];
        endcase
        cout = arith ? sum[W] : 1'b0;
        ovr  = arith ? (sum[W] ^ low[W-1]) : 1'b0;
        gacc = 1'b0;
        pacc = 1'b1;
        for (int k = 0; k < W; k++) begin
            gacc = (op_x[k] & op_y[k]) | ((op_x[k] | op_y[k]) & gacc);
            pacc = pacc & (op_x[k] | op_y[k]);
        end
        g_lo  = ~gacc;
        p_lo  = ~pacc;
        z     = (f == '0);
        f_msb = f[W-1];
    end

    always_comb begin
        reg_wr      = 1'b0;
        reg_wd      = f;
        q_next      = q_q;
        y_int       = f;
        ram_lsb_out = 1'b0;
        ram_msb_out = 1'b0;
        q_lsb_out   = 1'b0;
        q_msb_out   = 1'b0;
        ram_lsb_oe  = 1'b0;
        ram_msb_oe  = 1'b0;
        q_lsb_oe    = 1'b0;
        q_msb_oe    = 1'b0;
        case (dst)
            DST_QREG: q_next = f;
            DST_NOP:  ;
            DST_RAMA: begin reg_wr = 1'b1; y_int = rd_a; end
            DST_RAMF: reg_wr = 1'b1;
            DST_RAMQD, DST_RAMD: begin
                reg_wr      = 1'b1;
                reg_wd      = {ram_msb_in, f[W-1:1]};
                ram_lsb_out = f[0];
                ram_lsb_oe  = 1'b1;
                if (dst == DST_RAMQD) begin
                    q_next    = {q_msb_in, q_q[W-1:1]};
                    q_lsb_out = q_q[0];
                    q_lsb_oe  = 1'b1;
                end
            end
            DST_RAMQU, DST_RAMU: begin
                reg_wr      = 1'b1;
                reg_wd      = {f[W-2:0], ram_lsb_in};
                ram_msb_out = f[W-1];
                ram_msb_oe  = 1'b1;
                if (dst == DST_RAMQU) begin
                    q_next    = {q_q[W-2:0], q_lsb_in};
                    q_msb_out = q_q[W-1];
                    q_msb_oe  = 1'b1;
                end
            end
            default: ;
        endcase
        reg_we = reg_wr & wr_en;
        q_d    = wr_en ? q_next : q_q;
    end

    always_ff @(posedge cp) begin
        if (!reset_lo) q_q <= '0;
        else           q_q <= q_d;
    end

    always_ff @(posedge cp) begin
        if (!reset_lo) begin
            state_q <= REP_IDLE;
            ir_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                REP_IDLE: if (rep_start) begin
                    ir_q  <= i;
                    ra_q  <= a;
                    rb_q  <= b;
                    cnt_q <= rep_count;
                    if (rep_count == '0) begin
                        state_q <= REP_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= REP_BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                REP_BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= REP_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                REP_DONE: state_q <= REP_IDLE;
                default:  state_q <= REP_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = oe ? {W{1'bz}} : y_int;

endmodule

// File: tb/tb_bitslice_alu.sv
// Directed-vector bench: a W=4 instance for datapath/shift checks and a
// W=8 instance for the repeat sequencer and mid-repeat reset.
module tb_bitslice_alu;

    logic cp = 1'b0;
    always #5 cp = ~cp;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ins(input int sv, input int fv, input int dv);
        return {3'(dv), 3'(fv), 3'(sv)};
    endfunction

    task automatic tick;
        @(posedge cp);
        #1;
    endtask

    // W=4 instance
    logic       rl4, cin4, rli4, rmi4, qli4, qmi4, rs4;
    logic [8:0] i4;
    logic [3:0] a4, b4, d4;
    logic [7:0] rc4;
    wire  [3:0] y4;
    logic cout4, g4, p4, ovr4, z4, fm4, rlo4, rmo4, qlo4, qmo4;
    logic rloe4, rmoe4, qloe4, qmoe4, busy4, done4;

    bitslice_alu #(.W(4), .NREG(16), .CW(8)) dut4 (
        .cp(cp), .reset_lo(rl4), .i(i4), .a(a4), .b(b4), .d(d4), .cin(cin4),
        .oe(1'b0), .y(y4), .cout(cout4), .g_lo(g4), .p_lo(p4), .ovr(ovr4),
        .z(z4), .f_msb(fm4), .ram_lsb_in(rli4), .ram_msb_in(rmi4),
        .q_lsb_in(qli4), .q_msb_in(qmi4), .ram_lsb_out(rlo4), .ram_msb_out(rmo4),
        .q_lsb_out(qlo4), .q_msb_out(qmo4), .ram_lsb_oe(rloe4), .ram_msb_oe(rmoe4),
        .q_lsb_oe(qloe4), .q_msb_oe(qmoe4), .rep_start(rs4), .rep_count(rc4),
        .busy(busy4), .done(done4)
    );

    // W=8 instance
    logic       rl8, cin8, rs8;
    logic [8:0] i8;
    logic [3:0] a8, b8;
    logic [7:0] d8, rc8;
    wire  [7:0] y8;
    logic cout8, g8, p8, ovr8, z8, fm8, rlo8, rmo8, qlo8, qmo8;
    logic rloe8, rmoe8, qloe8, qmoe8, busy8, done8;

    bitslice_alu #(.W(8), .NREG(16), .CW(8)) dut8 (
        .cp(cp), .reset_lo(rl8), .i(i8), .a(a8), .b(b8), .d(d8), .cin(cin8),
        .oe(1'b0), .y(y8), .cout(cout8), .g_lo(g8), .p_lo(p8), .ovr(ovr8),
        .z(z8), .f_msb(fm8), .ram_lsb_in(1'b0), .ram_msb_in(1'b0),
        .q_lsb_in(1'b0), .q_msb_in(1'b0), .ram_lsb_out(rlo8), .ram_msb_out(rmo8),
        .q_lsb_out(qlo8), .q_msb_out(qmo8), .ram_lsb_oe(rloe8), .ram_msb_oe(rmoe8),
        .q_lsb_oe(qloe8), .q_msb_oe(qmoe8), .rep_start(rs8), .rep_count(rc8),
        .busy(busy8), .done(done8)
    );

    task automatic ld4(input logic [3:0] addr, input logic [3:0] val);
        i4 = ins(7, 3, 3); d4 = val; b4 = addr;
        tick;
    endtask

    task automatic rd4(input string tag, input logic [3:0] addr, input logic [3:0] exp);
        i4 = ins(4, 3, 1); a4 = addr;
        #1 chk(tag, y4, exp);
    endtask

    task automatic ld8(input logic [3:0] addr, input logic [7:0] val);
        i8 = ins(7, 3, 3); d8 = val; b8 = addr;
        tick;
    endtask

    initial begin
        rl4 = 1'b1; cin4 = 0; rli4 = 0; rmi4 = 0; qli4 = 0; qmi4 = 0; rs4 = 0;
        i4 = ins(4, 3, 1); a4 = 0; b4 = 0; d4 = 0; rc4 = 0;
        rl8 = 1'b1; cin8 = 0; rs8 = 0; i8 = ins(4, 3, 1); a8 = 0; b8 = 0; d8 = 0; rc8 = 0;

        // Reset
        rl4 = 0; rl8 = 0; tick; rl4 = 1; rl8 = 1;
        i4 = ins(4, 3, 1); a4 = 5;
        #1 chk("rst_y", y4, 4'h0);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        i4 = ins(2, 3, 1);
        #1 chk("rst_q", y4, 4'h0);

        // Load D into reg3 and read it back
        i4 = ins(7, 3, 3); d4 = 4'hA; b4 = 3;
        #1 chk("ld_y", y4, 4'hA);
        tick;
        rd4("ld_rd", 3, 4'hA);

        // 9 + 8: F=1, carry out, overflow, G asserted, P not
        ld4(1, 4'h9); ld4(2, 4'h8);
        i4 = ins(1, 0, 1); a4 = 1; b4 = 2; cin4 = 0;
        #1 chk("add_y", y4, 4'h1);
        chk("add_cout", cout4, 1);
        chk("add_ovr", ovr4, 1);
        chk("add_z", z4, 0);
        chk("add_glo", g4, 0);
        chk("add_plo", p4, 1);

        // AND forces carry/overflow low
        i4 = ins(1, 4, 1);
        #1 chk("and_y", y4, 4'h8);
        chk("and_cout", cout4, 0);
        chk("and_msb", fm4, 1);

        // S - R with R=S=5, cin=1: zero result
        ld4(1, 4'h5);
        i4 = ins(1, 1, 1); a4 = 1; b4 = 1; cin4 = 1;
        #1 chk("sub_y", y4, 4'h0);
        chk("sub_z", z4, 1);
        chk("sub_cout", cout4, 1);
        chk("sub_ovr", ovr4, 0);
        cin4 = 0;

        // dest2: y shows A while B takes F
        i4 = ins(7, 3, 2); d4 = 4'hC; a4 = 3; b4 = 4;
        #1 chk("rama_y", y4, 4'hA);
        tick;
        rd4("rama_rd", 4, 4'hC);

        // Down shift of B=6 and Q=3
        ld4(5, 4'h6);
        i4 = ins(7, 3, 0); d4 = 4'h3; tick;
        i4 = ins(3, 3, 4); b4 = 5; rmi4 = 1; qmi4 = 0;
        #1 chk("shd_y", y4, 4'h6);
        chk("shd_rlo", rlo4, 0);
        chk("shd_qlo", qlo4, 1);
        chk("shd_rloe", rloe4, 1);
        chk("shd_qloe", qloe4, 1);
        chk("shd_rmoe", rmoe4, 0);
        tick;
        rd4("shd_b", 5, 4'hB);
        i4 = ins(2, 3, 1);
        #1 chk("shd_q", y4, 4'h1);

        // Up shift of B=0xB and Q=1
        i4 = ins(3, 3, 6); b4 = 5; rli4 = 0; qli4 = 1;
        #1 chk("shu_rmo", rmo4, 1);
        chk("shu_qmo", qmo4, 0);
        chk("shu_rmoe", rmoe4, 1);
        chk("shu_qmoe", qmoe4, 1);
        chk("shu_rloe", rloe4, 0);
        tick;
        rd4("shu_b", 5, 4'h6);
        i4 = ins(2, 3, 1);
        #1 chk("shu_q", y4, 4'h3);

        // Repeat: reg1 doubles three times
        ld8(1, 8'h01);
        i8 = ins(1, 0, 3); a8 = 1; b8 = 1; cin8 = 0; rs8 = 1; rc8 = 3;
        #1 chk("acc_busy", busy8, 0);
        tick;
        // Live instruction and rep_start must be ignored while busy / done
        i8 = ins(7, 3, 3); d8 = 8'hFF; b8 = 1; rc8 = 2;
        for (int k = 0; k < 3; k++) begin
            #1 chk("rep_busy", busy8, 1);
            chk("rep_y", y8, 32'(8'h02 << k));
            chk("rep_done", done8, 0);
            if (k == 2) begin i8 = ins(4, 3, 1); a8 = 1; end
            tick;
        end
        #1 chk("rep_done_pulse", done8, 1);
        chk("rep_done_busy", busy8, 0);
        chk("rep_final", y8, 8'h08);
        tick;
        rs8 = 0;
        #1 chk("rep_idle_busy", busy8, 0);
        chk("rep_idle_done", done8, 0);

        // Zero repeat count: no busy, done next cycle
        i8 = ins(4, 3, 1); a8 = 1; rs8 = 1; rc8 = 0;
        tick;
        rs8 = 0;
        #1 chk("z0_done", done8, 1);
        chk("z0_busy", busy8, 0);
        tick;
        #1 chk("z0_done_end", done8, 0);

        // Reset after the first write aborts the repeat
        ld8(1, 8'h01);
        i8 = ins(1, 0, 3); a8 = 1; b8 = 1; rs8 = 1; rc8 = 3;
        tick;
        rs8 = 0; i8 = ins(4, 3, 1); a8 = 1;
        #1 chk("ab_busy", busy8, 1);
        tick;
        rl8 = 0; tick; rl8 = 1;
        #1 chk("ab_busy0", busy8, 0);
        chk("ab_done0", done8, 0);
        chk("ab_reg1", y8, 8'h00);
        tick;
        #1 chk("ab_no_done", done8, 0);
        chk("ab_idle", busy8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
